// File: rtl/uart_rx_frame_engine_if.sv
// RX frame engine result bus: word, status pulses and busy.
// master = engine side (drives), slave = consumer side (observes).
interface uart_rx_frame_engine_if #(
  parameter int MAX_DATA_WIDTH = 9
);
  logic [MAX_DATA_WIDTH-1:0] p_data;
  logic                      data_valid;
  logic                      parity_error;
  logic                      framing_error;
  logic                      break_det;
  logic                      busy;

  modport master (
    output p_data,
    output data_valid,
    output parity_error,
    output framing_error,
    output break_det,
    output busy
  );

  modport slave (
    input p_data,
    input data_valid,
    input parity_error,
    input framing_error,
    input break_det,
    input busy
  );
endinterface

// File: rtl/uart_rx_frame_engine.sv
// UART receive engine: sync, 3-sample vote, deserializer, parity/stop.
// In: clk, rst (async low), rx_in, per-frame config. Out: rx_o bus.
module uart_rx_frame_engine #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int SYNC_STAGES    = 2,
  parameter int PRESCALE_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [3:0]            data_len,
  input  logic                  par_enable,
  input  logic                  par_odd,
  input  logic                  two_stop,
  uart_rx_frame_engine_if.master rx_o
);
  localparam int DW = MAX_DATA_WIDTH;
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [3:0] LEN_MAX = 4'(DW);
  localparam logic [PRESCALE_W-1:0] PS_MIN = PRESCALE_W'(4);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, DONE
  } state_e;

  state_e                state_q, state_d;
  logic [SS-1:0]         sync_q, sync_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [PRESCALE_W-1:0] ps_q, ps_d;
  logic [3:0]            bit_q, bit_d;
  logic [3:0]            len_q, len_d;
  logic                  pen_q, pen_d;
  logic                  podd_q, podd_d;
  logic                  tstop_q, tstop_d;
  logic [2:0]            samp_q, samp_d;
  logic [DW-1:0]         shift_q, shift_d;
  logic [DW-1:0]         pdata_q, pdata_d;
  logic                  pacc_q, pacc_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  zero_q, zero_d;

  logic                  rx_s;
  logic                  bit_end;
  logic                  s2;
  logic                  vote;
  logic                  start_frame;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last;
  logic [PRESCALE_W-1:0] ps_eff;
  logic [3:0]            len_eff;

  assign sync_d  = {sync_q[SS-2:0], rx_in};
  assign rx_s    = sync_q[SS-1];
  assign half    = ps_q >> 1;
  assign last    = ps_q - 1'b1;
  assign bit_end = (edge_q == last);

  // With P=4 the third sample lands on the decision
  // cycle, so the vote takes that sample live.
  assign s2   = (edge_q == half + 1'b1) ? rx_s : samp_q[2];
  assign vote = (samp_q[0] & samp_q[1]) |
                (samp_q[0] & s2) |
                (samp_q[1] & s2);

  assign ps_eff = (prescale < PS_MIN) ? PS_MIN : prescale;

  always_comb begin
    len_eff = data_len;
    if (data_len < 4'd5) len_eff = 4'd5;
    else if (data_len > LEN_MAX) len_eff = LEN_MAX;
  end

  always_comb begin
    state_d     = state_q;
    edge_d      = edge_q;
    bit_d       = bit_q;
    ps_d        = ps_q;
    len_d       = len_q;
    pen_d       = pen_q;
    podd_d      = podd_q;
    tstop_d     = tstop_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    pdata_d     = pdata_q;
    pacc_d      = pacc_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    zero_d      = zero_q;
    start_frame = 1'b0;

    if (edge_q == half - 1'b1) samp_d[0] = rx_s;
    if (edge_q == half)        samp_d[1] = rx_s;
    if (edge_q == half + 1'b1) samp_d[2] = rx_s;

    if (state_q inside {START, DATA, PARITY, STOP1, STOP2})
      edge_d = bit_end ? '0 : edge_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d     = START;
          edge_d      = '0;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = vote ? IDLE : DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          for (int i = 0; i < DW; i++)
            if (bit_q == 4'(i)) shift_d[i] = vote;
          pacc_d = pacc_q ^ vote;
          if (vote) zero_d = 1'b0;
          if (bit_q == len_q - 4'd1) begin
            state_d = pen_q ? PARITY : STOP1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          if (vote != (pacc_q ^ podd_q)) perr_d = 1'b1;
          if (vote) zero_d = 1'b0;
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (bit_end) begin
          if (!vote) ferr_d = 1'b1;
          else       zero_d = 1'b0;
          if (tstop_q) begin
            state_d = STOP2;
          end else begin
            state_d = DONE;
            pdata_d = shift_q;
          end
        end
      end
      STOP2: begin
        if (bit_end) begin
          if (!vote) ferr_d = 1'b1;
          else       zero_d = 1'b0;
          state_d = DONE;
          pdata_d = shift_q;
        end
      end
      DONE: begin
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (!rx_s) begin
          // The line has already been low for one cycle
          // here, so this cycle stands in for edge 0.
          state_d     = START;
          edge_d      = PRESCALE_W'(1);
          start_frame = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      ps_d    = ps_eff;
      len_d   = len_eff;
      pen_d   = par_enable;
      podd_d  = par_odd;
      tstop_d = two_stop;
      bit_d   = '0;
      shift_d = '0;
      pacc_d  = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      zero_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sync_q  <= '1;
      edge_q  <= '0;
      bit_q   <= '0;
      ps_q    <= PS_MIN;
      len_q   <= 4'd5;
      pen_q   <= 1'b0;
      podd_q  <= 1'b0;
      tstop_q <= 1'b0;
      samp_q  <= '1;
      shift_q <= '0;
      pdata_q <= '0;
      pacc_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      ps_q    <= ps_d;
      len_q   <= len_d;
      pen_q   <= pen_d;
      podd_q  <= podd_d;
      tstop_q <= tstop_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      pdata_q <= pdata_d;
      pacc_q  <= pacc_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      zero_q  <= zero_d;
    end
  end

  assign rx_o.p_data        = pdata_q;
  assign rx_o.data_valid    = (state_q == DONE) & ~perr_q & ~ferr_q;
  assign rx_o.parity_error  = (state_q == DONE) & perr_q;
  assign rx_o.framing_error = (state_q == DONE) & ferr_q;
  assign rx_o.break_det     = (state_q == DONE) & zero_q;
  assign rx_o.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// Scoreboard bench for uart_rx_frame_engine.
// Frames are built from line rules; a monitor checks each result pulse.
module tb_uart_rx_frame_engine;
  localparam int DW = 9;
  localparam int SS = 2;
  localparam int PW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          valid;
    logic          perr;
    logic          ferr;
    logic          brk;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic [3:0]    data_len;
  logic          par_enable;
  logic          par_odd;
  logic          two_stop;
  logic [3:0]    pulses;

  int   vectors = 0;
  int   miscompares = 0;
  int   busy_run = 0;
  int   last_run = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  uart_rx_frame_engine_if #(.MAX_DATA_WIDTH(DW)) rx_if ();

  uart_rx_frame_engine #(
    .MAX_DATA_WIDTH(DW),
    .SYNC_STAGES(SS),
    .PRESCALE_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .prescale(prescale),
    .data_len(data_len),
    .par_enable(par_enable),
    .par_odd(par_odd),
    .two_stop(two_stop),
    .rx_o(rx_if)
  );

  always #5 clk = ~clk;

  assign pulses = {rx_if.data_valid, rx_if.parity_error,
                   rx_if.framing_error, rx_if.break_det};

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst && pulses != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {28'd0, pulses}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("p_data", 32'(rx_if.p_data), 32'(mon_e.data));
        check("flags", {28'd0, pulses},
              {28'd0, mon_e.valid, mon_e.perr, mon_e.ferr, mon_e.brk});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) busy_run = 0;
    else if (rx_if.busy) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  function automatic int eff_ps(input int raw);
    return (raw < 4) ? 4 : raw;
  endfunction

  function automatic int eff_len(input int raw);
    if (raw < 5) return 5;
    if (raw > DW) return DW;
    return raw;
  endfunction

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] data,
                            input int len_raw, input int ps_raw,
                            input bit pen, input bit podd,
                            input bit tstop, input bit flip_par,
                            input bit zero_stop, input int chg_ps);
    int            p;
    int            l;
    bit            bits[$];
    logic [DW-1:0] d;
    bit            pb;
    bit            all0;
    exp_t          e;
    p = eff_ps(ps_raw);
    l = eff_len(len_raw);
    d = '0;
    for (int i = 0; i < l; i++) d[i] = data[i];
    pb = (^d) ^ podd ^ flip_par;
    bits.push_back(1'b0);
    for (int i = 0; i < l; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pb);
    for (int i = 0; i < (tstop ? 2 : 1); i++)
      bits.push_back(!zero_stop);
    all0 = 1'b1;
    foreach (bits[i]) if (bits[i]) all0 = 1'b0;
    e.data  = d;
    e.perr  = pen && (pb != ((^d) ^ podd));
    e.ferr  = zero_stop;
    e.brk   = all0;
    e.valid = !e.perr && !e.ferr;
    exp_q.push_back(e);
    prescale   = PW'(ps_raw);
    data_len   = 4'(len_raw);
    par_enable = pen;
    par_odd    = podd;
    two_stop   = tstop;
    foreach (bits[i]) begin
      if (i == 4 && chg_ps != 0) prescale = PW'(chg_ps);
      rx_in = bits[i];
      repeat (p) @(negedge clk);
    end
  endtask

  initial begin
    exp_t e;
    int   n;
    int   gap;
    rst = 1'b0;
    rx_in = 1'b1;
    prescale = 8'd8;
    data_len = 4'd8;
    par_enable = 1'b0;
    par_odd = 1'b0;
    two_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(rx_if.busy), 32'd0);
    check("rst_p_data", 32'(rx_if.p_data), 32'd0);
    check("rst_pulses", {28'd0, pulses}, 32'd0);
    rst = 1'b1;
    idle(10);

    send_frame(9'h0A5, 8, 8, 0, 0, 0, 0, 0, 0);
    idle(20);
    check("frame_len", last_run, 81);

    send_frame(9'h035, 7, 16, 1, 0, 1, 0, 0, 0);
    idle(40);
    send_frame(9'h035, 7, 16, 1, 0, 1, 1, 0, 0);
    idle(40);

    prescale = 8'd8;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    n = 0;
    while (!rx_if.busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("glitch_busy_hi", 32'(rx_if.busy), 32'd1);
    n = 0;
    while (rx_if.busy && n < 8 + SS + 2) begin
      @(negedge clk);
      n++;
    end
    check("glitch_busy_lo", 32'(rx_if.busy), 32'd0);
    idle(20);

    send_frame(9'h000, 8, 8, 1, 1, 0, 0, 1, 0);
    idle(30);
    e.data  = '0;
    e.perr  = (1'b0 != (1'b0 ^ 1'b1));
    e.ferr  = 1'b1;
    e.brk   = 1'b1;
    e.valid = 1'b0;
    exp_q.push_back(e);
    // Line returns high after the break: the last low bit-time
    // reads as a start bit followed by all-ones data.
    e.data  = 9'h0FF;
    e.perr  = (1'b1 != ((^e.data) ^ 1'b1));
    e.ferr  = 1'b0;
    e.brk   = 1'b0;
    e.valid = !e.perr;
    exp_q.push_back(e);
    rx_in = 1'b0;
    repeat (12 * 8) @(negedge clk);
    idle(12 * 8 + 30);

    send_frame(9'h1FF, 9, 4, 1, 1, 0, 0, 0, 0);
    send_frame(9'h100, 9, 4, 1, 1, 0, 0, 0, 0);
    idle(60);

    send_frame(9'h05A, 8, 8, 0, 0, 0, 0, 0, 16);
    idle(30);
    prescale = 8'd8;
    rx_in = 1'b0;
    repeat (8) @(negedge clk);
    rx_in = 1'b1;
    repeat (8) @(negedge clk);
    rx_in = 1'b0;
    repeat (16) @(negedge clk);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    prescale = 8'd16;
    check("pre_rst_busy", 32'(rx_if.busy), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(rx_if.busy), 32'd0);
    check("rst_mid_p_data", 32'(rx_if.p_data), 32'd0);
    check("rst_mid_pulses", {28'd0, pulses}, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    idle(120);
    check("post_rst_busy", 32'(rx_if.busy), 32'd0);

    for (int k = 0; k < 30; k++) begin
      int ps;
      int ln;
      ps = $urandom_range(12, 2);
      ln = $urandom_range(12, 3);
      send_frame(DW'($urandom), ln, ps,
                 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)),
                 $urandom_range(5, 0) == 0,
                 $urandom_range(5, 0) == 0, 0);
      gap = ($urandom_range(2, 0) == 0) ? 0
            : $urandom_range(3 * eff_ps(ps), 1);
      idle(gap);
    end
    idle(20);

    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 32'd0);
    idle(50);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
